// File: rtl/bus_mem_slave_pkg.sv
// -----------------------------------------------------------------------------
// bus_mem_slave_pkg
// Shared definitions for the bus memory slave:
//   - default bus/memory geometry and wait-state count
//   - FSM state encoding (2 bits)
//   - helper that sizes the wait-state counter
// -----------------------------------------------------------------------------
package bus_mem_slave_pkg;

   localparam int BUS_DATA_W_DEF  = 64;
   localparam int BUS_ADR_W_DEF   = 14;
   localparam int MEM_DEPTH_DEF   = 16384;
   localparam int WAIT_CYCLES_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_RESP    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   // Counter must be able to hold WAIT_CYCLES-1; sized on WAIT_CYCLES+1 so a
   // WAIT_CYCLES of 1 still yields a 1-bit counter.
   function automatic int wait_cnt_w(input int wait_cycles);
      return $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/bus_mem_slave_array.sv
// -----------------------------------------------------------------------------
// bus_mem_array
// Synchronous single-port backing store, one word per address, 1-cycle read.
// Contents are never reset.
// Ports:
//   clk   in   clock, rising edge
//   we    in   write enable
//   addr  in   word index
//   din   in   write data
//   dout  out  registered read data (value at addr before this edge's write)
// -----------------------------------------------------------------------------
module bus_mem_array
   import bus_mem_slave_pkg::*;
#(
   parameter int DATA_W = BUS_DATA_W_DEF,
   parameter int DEPTH  = MEM_DEPTH_DEF,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] dout_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= din;
      end
      dout_q <= mem_q[addr];
   end

   assign dout = dout_q;

endmodule

// File: rtl/bus_mem_slave.sv
// -----------------------------------------------------------------------------
// bus_mem_slave
// Memory end of the shared cache/memory bus. Accepts one read or write at a
// time, answers with a one-cycle s_bus_ready pulse WAIT_CYCLES cycles after
// the request is accepted, then waits for the request lines to drop before
// accepting another.
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous reset, active-low
//   s_bus_address  in   word address (upper bits beyond the array index ignored)
//   s_bus_datain   in   write data
//   s_bus_dataout  out  read data, held until the next read completes
//   s_bus_rd       in   read request, level, held until ready
//   s_bus_wr       in   write request, level, held until ready (wins over rd)
//   s_bus_ready    out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module bus_mem_slave
   import bus_mem_slave_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = BUS_DATA_W_DEF,
   parameter int BUS_ADR_WIDTH  = BUS_ADR_W_DEF,
   parameter int MEM_DEPTH      = MEM_DEPTH_DEF,
   parameter int WAIT_CYCLES    = WAIT_CYCLES_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [BUS_ADR_WIDTH-1:0]  s_bus_address,
   input  logic [BUS_DATA_WIDTH-1:0] s_bus_datain,
   output logic [BUS_DATA_WIDTH-1:0] s_bus_dataout,
   input  logic                      s_bus_rd,
   input  logic                      s_bus_wr,
   output logic                      s_bus_ready
);

   localparam int IDX_W = $clog2(MEM_DEPTH);
   localparam int CNT_W = wait_cnt_w(WAIT_CYCLES);

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [BUS_DATA_WIDTH-1:0] dout_q, dout_d;
   logic [IDX_W-1:0]          addr_q, addr_d;
   logic [BUS_DATA_WIDTH-1:0] data_q, data_d;
   logic                      op_wr_q, op_wr_d;

   logic                      ram_we;
   logic [IDX_W-1:0]          ram_addr;
   logic [BUS_DATA_WIDTH-1:0] ram_dout;

   // Address bits above the array index are deliberately dropped (wrap).
   logic addr_unused;
   assign addr_unused = ^s_bus_address;

   bus_mem_array #(
      .DATA_W (BUS_DATA_WIDTH),
      .DEPTH  (MEM_DEPTH)
   ) u_array (
      .clk  (clk),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (data_q),
      .dout (ram_dout)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      addr_d   = addr_q;
      data_d   = data_q;
      op_wr_d  = op_wr_q;
      ram_we   = 1'b0;
      ram_addr = addr_q;

      case (state_q)
         ST_IDLE: begin
            // Present the incoming address to the RAM in IDLE so its 1-cycle
            // read is already valid when a WAIT_CYCLES=1 transfer completes.
            ram_addr = s_bus_address[IDX_W-1:0];
            if (s_bus_rd || s_bus_wr) begin
               addr_d  = s_bus_address[IDX_W-1:0];
               data_d  = s_bus_datain;
               op_wr_d = s_bus_wr;
               cnt_d   = CNT_W'(WAIT_CYCLES - 1);
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) begin
               state_d = ST_RESP;
               if (op_wr_q) begin
                  ram_we = 1'b1;
               end else begin
                  dout_d = ram_dout;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            state_d = ST_RELEASE;
         end
         ST_RELEASE: begin
            // Hold off until the requester drops its level request so the
            // same request is never accepted twice.
            if (!s_bus_rd && !s_bus_wr) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dout_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
      end
   end

   // Request latches carry data only; their value is irrelevant outside a
   // transaction, so they are not reset.
   always_ff @(posedge clk) begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      op_wr_q <= op_wr_d;
   end

   assign s_bus_ready   = (state_q == ST_RESP);
   assign s_bus_dataout = dout_q;

endmodule
